wb_uart_master: RTL and testbench



---
 rtl/wb_uart_master_pkg.sv | 21 ++
 rtl/wb_uart_master.sv | 177 +++++++++++++++++
 tb/tb_wb_uart_master.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_master_pkg.sv
// rtl/wb_uart_master_pkg.sv - opcodes, response bytes and FSM states of the UART-to-Wishbone bridge
package wb_uart_master_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS,
    ST_GAP,
    ST_RESP,
    ST_RDATA,
    ST_BADOP
  } state_t;

endpackage

// File: rtl/wb_uart_master.sv
// rtl/wb_uart_master.sv - command byte stream to Wishbone B3 classic master bridge
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic        rx_rdy_o,
  output logic [7:0]  tx_dat_o,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        busy_o
);

  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [3:0]  retry_cnt;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [7:0]  tx_dat_q;
  logic        tx_vld_q;
  logic        cyc_q;
  logic        we_q;
  logic        is_wr;
  logic        rsp_ok;
  logic        run_q;
  logic        rx_fire;
  logic        tx_fire;

  // run_q keeps rx_rdy_o and sel low during reset and rises on the first edge after it
  assign rx_rdy_o = run_q & ((state == ST_IDLE) | (state == ST_ADDR) | (state == ST_WDATA));
  assign rx_fire  = rx_vld_i & rx_rdy_o;
  assign tx_fire  = tx_vld_q & tx_rdy_i;

  assign tx_dat_o  = tx_dat_q;
  assign tx_vld_o  = tx_vld_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = {4{run_q}};
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= ST_IDLE;
      byte_cnt  <= 2'd0;
      tmo_cnt   <= 16'd0;
      retry_cnt <= 4'd0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      tx_dat_q  <= 8'd0;
      tx_vld_q  <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      is_wr     <= 1'b0;
      rsp_ok    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_IDLE: if (rx_fire) begin
          byte_cnt <= 2'd0;
          is_wr    <= (rx_dat_i == OP_WR);
          state    <= (rx_dat_i == OP_WR || rx_dat_i == OP_RD) ? ST_ADDR : ST_BADOP;
        end
        ST_ADDR: if (rx_fire) begin
          adr_q    <= {adr_q[23:0], rx_dat_i};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (is_wr) begin
              state <= ST_WDATA;
            end else begin
              state     <= ST_BUS;
              cyc_q     <= 1'b1;
              we_q      <= 1'b0;
              tmo_cnt   <= TMO_LOAD;
              retry_cnt <= 4'd0;
            end
          end
        end
        ST_WDATA: if (rx_fire) begin
          dat_q    <= {dat_q[23:0], rx_dat_i};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state     <= ST_BUS;
            cyc_q     <= 1'b1;
            we_q      <= 1'b1;
            tmo_cnt   <= TMO_LOAD;
            retry_cnt <= 4'd0;
          end
        end
        ST_BUS: begin
          tmo_cnt <= tmo_cnt - 16'd1;
          // err beats ack beats rty when a slave raises several at once
          if (wbm_err_i || wbm_ack_i) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            tx_vld_q <= 1'b1;
            tx_dat_q <= wbm_err_i ? RSP_ERR : RSP_OK;
            rsp_ok   <= !wbm_err_i;
            if (!wbm_err_i && !is_wr) dat_q <= wbm_dat_i;
            state    <= ST_RESP;
          end else if (wbm_rty_i && retry_cnt < RETRY_LIM) begin
            cyc_q     <= 1'b0;
            retry_cnt <= retry_cnt + 4'd1;
            state     <= ST_GAP;
          end else if (wbm_rty_i || tmo_cnt == 16'd1) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            tx_vld_q <= 1'b1;
            tx_dat_q <= RSP_ERR;
            rsp_ok   <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_GAP: begin
          cyc_q   <= 1'b1;
          tmo_cnt <= TMO_LOAD;
          state   <= ST_BUS;
        end
        ST_BADOP: begin
          tx_vld_q <= 1'b1;
          tx_dat_q <= RSP_BAD;
          rsp_ok   <= 1'b0;
          state    <= ST_RESP;
        end
        ST_RESP: if (tx_fire) begin
          if (rsp_ok && !is_wr) begin
            tx_dat_q <= dat_q[31:24];
            dat_q    <= {dat_q[23:0], 8'h00};
            byte_cnt <= 2'd0;
            state    <= ST_RDATA;
          end else begin
            tx_vld_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RDATA: if (tx_fire) begin
          if (byte_cnt == 2'd3) begin
            tx_vld_q <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tx_dat_q <= dat_q[31:24];
            dat_q    <= {dat_q[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_master.sv
// tb/tb_wb_uart_master.sv - randomized bench for wb_uart_master against a transaction-level model
module tb_wb_uart_master;
  import wb_uart_master_pkg::*;

  localparam int TMO = 8;
  localparam int MAXR = 4;
  localparam int M_ACK = 0, M_ERR = 1, M_ERRACK = 2, M_SILENT = 3, M_RTY = 4;

  logic clk = 0, rst_n = 0;
  logic [7:0] rx_dat = 0, tx_dat;
  logic rx_vld = 0, rx_rdy, tx_vld, tx_rdy = 0, busy;
  logic [31:0] wbm_adr_o, wbm_dat_o, dat_i = 0;
  logic [3:0] wbm_sel_o;
  logic [2:0] wbm_cti_o;
  logic [1:0] wbm_bte_o;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, ack_i = 0, err_i = 0, rty_i = 0;

  int checks = 0, failures = 0;
  int s_mode = M_ACK, s_wait = 0, s_nrty = 0;
  logic [31:0] s_rdata = 0;
  int pulses = 0, hi_cycles = 0, gap = 0, wcnt = 0, stb_bad = 0;
  bit in_pulse = 0, tx_hold = 0, tx_rand = 0, cyc_after_last = 0;
  int gaps[$];
  logic [7:0] tx_q[$];
  logic [31:0] snap_adr = 0, snap_dat = 0;
  logic snap_we = 0;
  logic [8:0] snap_const = 0;

  wb_uart_master #(.TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .rx_dat_i(rx_dat), .rx_vld_i(rx_vld), .rx_rdy_o(rx_rdy),
    .tx_dat_o(tx_dat), .tx_vld_o(tx_vld), .tx_rdy_i(tx_rdy),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Slave model: answers after s_wait wait states and logs pulse/gap shape
  always @(negedge clk) begin
    ack_i = 0; err_i = 0; rty_i = 0; dat_i = $urandom;
    if (rst_n && wbm_stb_o !== wbm_cyc_o) stb_bad++;
    if (rst_n && wbm_cyc_o) begin
      if (!in_pulse) begin
        in_pulse = 1; pulses++; wcnt = 0;
        if (pulses > 1) gaps.push_back(gap);
      end
      hi_cycles++;
      if (s_mode != M_SILENT && wcnt == s_wait) begin
        case (s_mode)
          M_ACK:    ack_i = 1;
          M_ERR:    err_i = 1;
          M_ERRACK: begin ack_i = 1; err_i = 1; end
          default:  if (pulses <= s_nrty) rty_i = 1; else ack_i = 1;
        endcase
        if (ack_i) dat_i = s_rdata;
        snap_adr = wbm_adr_o; snap_dat = wbm_dat_o; snap_we = wbm_we_o;
        snap_const = {wbm_sel_o, wbm_cti_o, wbm_bte_o};
      end
      wcnt++;
    end else begin
      if (in_pulse) begin in_pulse = 0; gap = 0; end
      gap++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) tx_rdy = 0;
    else begin
      tx_rdy = !tx_hold && (!tx_rand || $urandom_range(0, 1) == 1);
      if (tx_rdy && tx_vld) tx_q.push_back(tx_dat);
    end
  end

  function automatic bit model_ok(input int mode, input int nrty);
    if (mode == M_ACK) return 1;
    if (mode == M_RTY) return nrty <= MAXR;
    return 0;
  endfunction

  function automatic int model_pulses(input int mode, input int nrty);
    if (mode == M_RTY) return ((nrty < MAXR) ? nrty : MAXR) + 1;
    return 1;
  endfunction

  function automatic logic [47:0] pack(input logic [7:0] q[$]);
    logic [47:0] v = '0;
    v[47:40] = 8'(q.size());
    foreach (q[i]) if (i < 5) v[39-8*i -: 8] = q[i];
    return v;
  endfunction

  function automatic logic [47:0] model_resp(input logic [7:0] op, input bit ok, input logic [31:0] rd);
    logic [7:0] q[$];
    if (op != OP_WR && op != OP_RD) q.push_back(RSP_BAD);
    else if (!ok) q.push_back(RSP_ERR);
    else begin
      q.push_back(RSP_OK);
      if (op == OP_RD) for (int i = 0; i < 4; i++) q.push_back(rd[31-8*i -: 8]);
    end
    return pack(q);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle);
    int n = 0;
    rx_vld = 0;
    repeat (idle) @(negedge clk);
    rx_dat = b; rx_vld = 1;
    while (rx_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    rx_vld = 0;
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL rx_accept_bound got=stalled exp=accepted byte=%h", b);
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit rnd_idle, output bit done);
    int n = 0;
    pulses = 0; hi_cycles = 0; gaps.delete(); tx_q.delete();
    snap_adr = '0; snap_dat = '0; snap_we = 0; snap_const = '0;
    send_byte(op, rnd_idle ? $urandom_range(0, 2) : 0);
    if (op == OP_WR || op == OP_RD)
      for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], rnd_idle ? $urandom_range(0, 2) : 0);
    if (op == OP_WR)
      for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8], rnd_idle ? $urandom_range(0, 2) : 0);
    cyc_after_last = wbm_cyc_o;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    done = (n < 1000);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_rdy, busy, tx_vld, tx_dat, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
         wbm_adr_o, wbm_dat_o, wbm_cti_o, wbm_bte_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got=nonzero exp=0 sel=%h cyc=%b rx_rdy=%b", wbm_sel_o, wbm_cyc_o, rx_rdy);
    end
    rst_n = 1;
    #1;
    checks++;
    if (rx_rdy !== 1'b0) begin failures++; $display("FAIL rx_rdy_before_edge got=%b exp=0", rx_rdy); end
    @(negedge clk);
    checks++;
    if (rx_rdy !== 1'b1) begin failures++; $display("FAIL rx_rdy_after_edge got=%b exp=1", rx_rdy); end
  endtask

  task automatic test_reset_midcmd();
    bit done;
    send_byte(OP_WR, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    rst_n = 0;
    #1;
    checks++;
    if ({busy, rx_rdy, wbm_adr_o} !== '0) begin
      failures++; $display("FAIL midcmd_reset got=busy%b rdy%b adr%h exp=0", busy, rx_rdy, wbm_adr_o);
    end
    @(negedge clk); rst_n = 1; @(negedge clk);
    s_mode = M_ACK; s_wait = 1;
    run_cmd(OP_WR, 32'hA5A5_0004, 32'h0102_0304, 0, done);
    checks++;
    if (pack(tx_q) !== model_resp(OP_WR, 1, 0) || !done) begin
      failures++; $display("FAIL midcmd_resp got=%h exp=%h", pack(tx_q), model_resp(OP_WR, 1, 0));
    end
    checks++;
    if (snap_adr !== 32'hA5A5_0004) begin failures++; $display("FAIL midcmd_adr got=%h exp=a5a50004", snap_adr); end
  endtask

  task automatic test_write();
    bit done;
    s_mode = M_ACK; s_wait = 0;
    run_cmd(OP_WR, 32'h0000_0100, 32'hDEAD_BEEF, 0, done);
    checks++;
    if (cyc_after_last !== 1'b1) begin failures++; $display("FAIL write_cyc_latency got=%b exp=1", cyc_after_last); end
    checks++;
    if ({snap_adr, snap_dat, snap_we, snap_const} !== {32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 5'b0}) begin
      failures++; $display("FAIL write_bus got=%h/%h/%b/%h exp=100/deadbeef/1/1e0", snap_adr, snap_dat, snap_we, snap_const);
    end
    checks++;
    if (pulses !== 1 || hi_cycles !== 1) begin failures++; $display("FAIL write_shape got=%0d/%0d exp=1/1", pulses, hi_cycles); end
    checks++;
    if (pack(tx_q) !== model_resp(OP_WR, 1, 0) || !done) begin
      failures++; $display("FAIL write_resp got=%h exp=%h", pack(tx_q), model_resp(OP_WR, 1, 0));
    end
  endtask

  task automatic test_read();
    bit done;
    s_mode = M_ACK; s_wait = 3; s_rdata = 32'h1234_5678;
    run_cmd(OP_RD, 32'h0000_0100, 0, 0, done);
    checks++;
    if (pack(tx_q) !== model_resp(OP_RD, 1, 32'h1234_5678) || !done) begin
      failures++; $display("FAIL read_resp got=%h exp=%h", pack(tx_q), model_resp(OP_RD, 1, 32'h1234_5678));
    end
    checks++;
    if (hi_cycles !== 4 || snap_we !== 1'b0 || snap_adr !== 32'h100) begin
      failures++; $display("FAIL read_shape got=cyc%0d we%b adr%h exp=cyc4 we0 adr100", hi_cycles, snap_we, snap_adr);
    end
  endtask

  task automatic test_err_priority();
    bit done;
    s_mode = M_ERRACK; s_wait = 1; s_rdata = 32'hCAFE_F00D;
    run_cmd(OP_RD, 32'h0000_0040, 0, 0, done);
    checks++;
    if (pack(tx_q) !== model_resp(OP_RD, 0, 0) || !done) begin
      failures++; $display("FAIL err_priority got=%h exp=%h", pack(tx_q), model_resp(OP_RD, 0, 0));
    end
  endtask

  task automatic test_timeout();
    bit done;
    s_mode = M_SILENT;
    run_cmd(OP_WR, 32'h0000_0200, 32'h5555_AAAA, 0, done);
    checks++;
    if (pulses !== 1 || hi_cycles !== TMO) begin
      failures++; $display("FAIL timeout_shape got=%0d/%0d exp=1/%0d", pulses, hi_cycles, TMO);
    end
    checks++;
    if (pack(tx_q) !== model_resp(OP_WR, 0, 0) || !done) begin
      failures++; $display("FAIL timeout_resp got=%h exp=%h", pack(tx_q), model_resp(OP_WR, 0, 0));
    end
  endtask

  task automatic test_retry();
    bit done;
    int bad_gap;
    s_mode = M_RTY; s_nrty = 2; s_wait = 0;
    run_cmd(OP_WR, 32'h0000_0300, 32'h0BAD_CAFE, 0, done);
    bad_gap = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad_gap++;
    checks++;
    if (pulses !== 3 || bad_gap !== 0 || gaps.size() !== 2) begin
      failures++; $display("FAIL retry_shape got=pulses%0d badgap%0d exp=pulses3 badgap0", pulses, bad_gap);
    end
    checks++;
    if (pack(tx_q) !== model_resp(OP_WR, 1, 0) || !done) begin
      failures++; $display("FAIL retry_resp got=%h exp=%h", pack(tx_q), model_resp(OP_WR, 1, 0));
    end
    s_nrty = 1000;
    run_cmd(OP_WR, 32'h0000_0304, 32'h1, 0, done);
    checks++;
    if (pulses !== MAXR + 1) begin failures++; $display("FAIL retry_exhaust_pulses got=%0d exp=%0d", pulses, MAXR + 1); end
    checks++;
    if (pack(tx_q) !== model_resp(OP_WR, 0, 0) || !done) begin
      failures++; $display("FAIL retry_exhaust_resp got=%h exp=%h", pack(tx_q), model_resp(OP_WR, 0, 0));
    end
  endtask

  task automatic test_bad_op_backpressure();
    int n = 0, bad = 0;
    pulses = 0; tx_q.delete();
    tx_hold = 1;
    send_byte(8'h00, 0);
    while (tx_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      if (tx_vld !== 1'b1 || tx_dat !== RSP_BAD || rx_rdy !== 1'b0 || wbm_cyc_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0 || n >= 20) begin failures++; $display("FAIL badop_hold got=%0d_bad_cycles exp=0", bad); end
    tx_hold = 0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (pack(tx_q) !== model_resp(8'h00, 0, 0) || pulses !== 0) begin
      failures++; $display("FAIL badop_resp got=%h pulses%0d exp=%h pulses0", pack(tx_q), pulses, model_resp(8'h00, 0, 0));
    end
    checks++;
    if (rx_rdy !== 1'b1) begin failures++; $display("FAIL badop_rx_rdy got=%b exp=1", rx_rdy); end
  endtask

  task automatic test_random();
    bit done, ok;
    logic [7:0] op;
    logic [31:0] a, d;
    int exp_hi, exp_p;
    tx_rand = 1;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0, 1: op = OP_WR;
        2, 3: op = OP_RD;
        default: begin op = 8'($urandom); if (op == OP_WR || op == OP_RD) op = 8'h00; end
      endcase
      a = $urandom; d = $urandom; s_rdata = $urandom;
      s_mode = $urandom_range(0, 4); s_wait = $urandom_range(0, 3); s_nrty = $urandom_range(0, 6);
      run_cmd(op, a, d, 1, done);
      ok = model_ok(s_mode, s_nrty);
      exp_p = (op == OP_WR || op == OP_RD) ? model_pulses(s_mode, s_nrty) : 0;
      exp_hi = (exp_p == 0) ? 0 : (s_mode == M_SILENT) ? TMO : exp_p * (s_wait + 1);
      checks++;
      if (pack(tx_q) !== model_resp(op, ok, s_rdata) || !done) begin
        failures++; $display("FAIL rand_resp[%0d] got=%h exp=%h", it, pack(tx_q), model_resp(op, ok, s_rdata));
      end
      checks++;
      if (pulses !== exp_p || hi_cycles !== exp_hi) begin
        failures++; $display("FAIL rand_shape[%0d] got=%0d/%0d exp=%0d/%0d", it, pulses, hi_cycles, exp_p, exp_hi);
      end
      if (exp_p != 0 && s_mode != M_SILENT) begin
        checks++;
        if (snap_adr !== a || snap_we !== (op == OP_WR) || (op == OP_WR && snap_dat !== d)) begin
          failures++; $display("FAIL rand_bus[%0d] got=%h/%h/%b exp=%h/%h/%b", it, snap_adr, snap_dat, snap_we, a, d, op == OP_WR);
        end
      end
    end
    tx_rand = 0;
    checks++;
    if (stb_bad !== 0) begin failures++; $display("FAIL stb_tracks_cyc got=%0d exp=0", stb_bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_err_priority();
    test_timeout();
    test_retry();
    test_bad_op_backpressure();
    test_reset_midcmd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
